vote_button_arbiter: RTL
========================

// Module: vote_button_arbiter
// PURPOSE
//  Parametrised front end for the candidate buttons of the voting machine.
//  - Debounces N_CAND raw buttons with one saturating hold counter per channel.
//  - Accepts exactly one qualified press per voting cycle and emits a one-cycle vote_logged pulse with a one-hot candidate.
//  - Rejects simultaneous presses and enforces a release window between votes.
//  - Sits between the button pads and the vote-count/validation logic.
// PARAMETERS
//  N_CAND          4     number of candidate buttons (>=2)
//  HOLD_CYCLES     4     consecutive high samples needed to qualify a press (>=1)
//  RELEASE_CYCLES  2     consecutive all-released samples needed to re-arm (>=1)
//  STUCK_CYCLES    1000  held-button cycles before stuck flag (used only with STUCK_DETECT_EN)
// PORTS
//  clk             in   1       system clock, rising edge
//  reset           in   1       asynchronous, active-low reset
//  mode            in   1       0 = voting, 1 = result/display (votes blocked)
//  button          in   N_CAND  raw candidate buttons, active-high, synchronous to clk
//  vote_logged     out  1       one-cycle pulse: one valid vote accepted
//  vote_candidate  out  N_CAND  one-hot candidate of last accepted vote; holds until next vote
//  multi_press     out  1       one-cycle pulse: >1 channel qualified on the same edge, vote rejected
//  stuck           out  1       level: a button is held too long (tied 0 without STUCK_DETECT_EN)
// BEHAVIOUR
//  Reset (reset=0, async)
//   - All outputs 0; hold, release and stuck counters 0; FSM = ARMED.
//   - Release mid-count: counting restarts from 0; no vote is produced from pre-reset samples.
//  Per-channel hold counter cnt[i], width $clog2(HOLD_CYCLES+1)
//   - button[i]=1 and cnt[i]<HOLD_CYCLES: cnt[i] <= cnt[i]+1.
//   - button[i]=1 and cnt[i]=HOLD_CYCLES: cnt[i] holds (saturates).
//   - button[i]=0: cnt[i] <= 0.
//   - Counters run in every state and mode. sat[i] = (cnt[i]==HOLD_CYCLES).
//  FSM states: ARMED, LOCKED
//   - ARMED, mode=0, exactly one sat[i]:
//     vote_logged<=1, vote_candidate<=one-hot(i), -> LOCKED.
//   - ARMED, mode=0, two or more sat:
//     multi_press<=1, vote_candidate unchanged, -> LOCKED.
//   - ARMED, no sat: stay in ARMED.
//   - LOCKED, button==0: rel_cnt <= rel_cnt+1.
//   - LOCKED, any button high: rel_cnt <= 0.
//   - LOCKED -> ARMED on the edge where rel_cnt reaches RELEASE_CYCLES; rel_cnt then cleared.
//   - mode=1 in either state: force LOCKED, clear rel_cnt, no vote_logged/multi_press.
//     A press held across the mode=1 -> 0 change never votes.
//  Latency and pulse rules
//   - button[i] sampled high at edges 1..HOLD_CYCLES; vote_logged is high after edge HOLD_CYCLES+1.
//   - vote_logged and multi_press are registered, never both high, and never high on consecutive cycles.
//   - Any low sample before saturation restarts the count (bounce rejection).
//   - A channel qualifying one edge after another channel's vote is ignored (FSM already LOCKED).
// CONFIGURATION
//  STUCK_DETECT_EN defined:
//   - Saturating counter st_cnt increments while FSM=LOCKED and button!=0; cleared when button==0.
//   - stuck=1 while st_cnt==STUCK_CYCLES.
//   - stuck never blocks reset or mode handling.
//  STUCK_DETECT_EN undefined:
//   - No st_cnt logic; stuck tied to 0.
// TESTING (defaults: N_CAND=4, HOLD=4, RELEASE=2)
//  1. Reset, mode=0, button=0010 held 8 cycles
//     -> single vote_logged pulse after edge 5, vote_candidate=0010, no further pulse while held.
//  2. button=0001 high 3, low 1, high 3, then low
//     -> no vote_logged, vote_candidate stays 0000.
//  3. button=0011 held 6 cycles
//     -> multi_press pulse after edge 5, no vote_logged, vote_candidate unchanged.
//  4. After test 1: release 1 cycle, hold 0100 for 6 -> no vote.
//     Then release 2 cycles, hold 0100 for 6 -> vote_logged after 5th held edge, vote_candidate=0100.
//  5. mode=1, button=1000 held 10 -> no pulses; mode->0 while held -> no vote.
//     Release 2 cycles, hold 5 -> vote, vote_candidate=1000.
//  6. reset low asynchronously at cnt=3 -> outputs 0 immediately, no pulse after release.
//     With STUCK_DETECT_EN: vote, keep holding 1000 cycles -> stuck=1; release -> stuck=0 next cycle.

Source files
------------

// File: rtl/vote_button_arbiter.sv
// ---------------------------------------------------------------------------
// vote_button_arbiter
//
// Front end for the candidate buttons of the voting machine. Each raw button
// is debounced by a saturating hold counter. Exactly one qualified press per
// voting cycle is accepted and reported as a one-cycle vote_logged pulse with
// a one-hot candidate. Simultaneous qualified presses are rejected with a
// multi_press pulse. All buttons must then stay released for RELEASE_CYCLES
// samples before the next vote can be taken. While mode=1 (result/display)
// votes are blocked.
//
// Optional feature (compile-time macro STUCK_DETECT_EN):
//   When defined, a saturating counter flags a button that is held for
//   STUCK_CYCLES cycles while locked. When undefined, stuck is tied to 0.
//
// Ports
//   clk             in   1       system clock, rising edge
//   reset           in   1       asynchronous, active-low reset
//   mode            in   1       0 = voting, 1 = result/display (votes blocked)
//   button          in   N_CAND  raw candidate buttons, active-high
//   vote_logged     out  1       one-cycle pulse: one valid vote accepted
//   vote_candidate  out  N_CAND  one-hot candidate of last accepted vote
//   multi_press     out  1       one-cycle pulse: simultaneous press rejected
//   stuck           out  1       level: a button is held too long
// ---------------------------------------------------------------------------
module vote_button_arbiter #(
   parameter int N_CAND         = 4,
   parameter int HOLD_CYCLES    = 4,
   parameter int RELEASE_CYCLES = 2,
   parameter int STUCK_CYCLES   = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode,
   input  logic [N_CAND-1:0] button,
   output logic              vote_logged,
   output logic [N_CAND-1:0] vote_candidate,
   output logic              multi_press,
   output logic              stuck
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam int RW = $clog2(RELEASE_CYCLES + 1);

   typedef enum logic {
      ARMED  = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Reject parameter sets the counter widths and arbitration cannot support.
   if (N_CAND < 2 || HOLD_CYCLES < 1 || RELEASE_CYCLES < 1 || STUCK_CYCLES < 1) begin : g_bad_params
      $error("vote_button_arbiter: illegal parameter value");
   end

   logic [CW-1:0]     r_cnt [N_CAND];
   logic [N_CAND-1:0] w_sat;
   logic              w_any_sat;
   logic              w_one_sat;
   state_t            r_state;
   logic [RW-1:0]     r_rel_cnt;

   // Debounce: one saturating hold counter per channel; a low sample restarts it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the counter array feeds qualification directly, so every entry
         // is reset; leaving it unreset would let pre-reset samples cast a vote.
         for (int i = 0; i < N_CAND; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CAND; i++) begin
            if (!button[i])
               r_cnt[i] <= '0;
            else if (r_cnt[i] != CW'(HOLD_CYCLES))
               // NOTE: non-blocking so every counter updates from the same
               // pre-edge snapshot, independent of statement order.
               r_cnt[i] <= r_cnt[i] + CW'(1);
         end
      end
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves w_sat unassigned (no latch).
      w_sat = '0;
      for (int i = 0; i < N_CAND; i++) w_sat[i] = (r_cnt[i] == CW'(HOLD_CYCLES));
   end

   // Exactly one bit set <=> non-zero and clearing the lowest set bit leaves zero.
   assign w_any_sat = (w_sat != '0);
   assign w_one_sat = w_any_sat && ((w_sat & (w_sat - N_CAND'(1))) == '0);

   // Arbitration FSM with registered pulse and candidate outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= ARMED;
         r_rel_cnt      <= '0;
         vote_logged    <= 1'b0;
         multi_press    <= 1'b0;
         vote_candidate <= '0;
      end else begin
         vote_logged <= 1'b0;
         multi_press <= 1'b0;
         if (mode) begin
            // Display mode blocks voting; a press held across the return to
            // voting mode must be released before it can count.
            r_state   <= LOCKED;
            r_rel_cnt <= '0;
         end else begin
            case (r_state)
               ARMED: begin
                  if (w_any_sat) begin
                     r_state <= LOCKED;
                     if (w_one_sat) begin
                        vote_logged    <= 1'b1;
                        vote_candidate <= w_sat;
                     end else begin
                        multi_press <= 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  if (button == '0) begin
                     // Re-arm on the edge that completes the release window.
                     if (r_rel_cnt == RW'(RELEASE_CYCLES - 1)) begin
                        r_state   <= ARMED;
                        r_rel_cnt <= '0;
                     end else begin
                        r_rel_cnt <= r_rel_cnt + RW'(1);
                     end
                  end else begin
                     r_rel_cnt <= '0;
                  end
               end
               default: r_state <= ARMED;
            endcase
         end
      end
   end

`ifdef STUCK_DETECT_EN
   localparam int SW = $clog2(STUCK_CYCLES + 1);

   logic [SW-1:0] r_st_cnt;

   // Counts locked cycles with any button down; a full release clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_st_cnt <= '0;
      else if (button == '0)
         r_st_cnt <= '0;
      else if (r_state == LOCKED && r_st_cnt != SW'(STUCK_CYCLES))
         r_st_cnt <= r_st_cnt + SW'(1);
   end

   assign stuck = (r_st_cnt == SW'(STUCK_CYCLES));
`else
   assign stuck = 1'b0;
`endif

endmodule
